// File: rtl/bcd_round_seq.sv
// bcd_round_seq: sequential binary-to-BCD converter with half-up rounding.
// Converts BIN_W-bit binary to 7 BCD digits (shift-add-3, one bit per clock),
// rounds away the last digit to a 1-bit leading digit plus 5 BCD digits,
// saturating at 1_99999, and presents the result on a valid/ready handshake.
// Optional feature macro: BCD_SIGNED_EN (two's complement input, sign on out_neg).
module bcd_round_seq #(
  parameter int unsigned BIN_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hi,
  output logic [19:0]      out_digits,
  output logic             out_ovf,
  output logic             out_neg,
  output logic             busy
);

  localparam int unsigned ACC_W = 28;
  localparam int unsigned DIG_W = 20;
  localparam int unsigned CMP_W = 22;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(1999999);

  typedef enum logic [1:0] {IDLE, CONV, ROUND, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [BIN_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;

  logic [BIN_W-1:0] mag_c;
  logic [ACC_W-2:0] acc_adj_c;
  logic [DIG_W-1:0] rnd_digits_c;
  logic             rnd_hi_c;
  logic             rnd_ovf_c;
  logic             carry_c;
  logic [3:0]       nib_c;

  // Magnitude of the incoming value (sign stripped when signed input is enabled).
  always_comb begin
    mag_c = in_bin;
`ifdef BCD_SIGNED_EN
    if (in_bin[BIN_W-1]) begin
      mag_c = ~in_bin + BIN_W'(1);
    end
`endif
  end

  // Add-3 correction on the six low digits; the leading digit never reaches 5 before its last shift.
  always_comb begin
    acc_adj_c = acc[ACC_W-2:0];
    for (int i = 0; i < 6; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Half-up rounding on the last digit with decimal carry and saturation at 1_99999.
  always_comb begin
    carry_c      = (acc[3:0] >= 4'd5);
    nib_c        = 4'd0;
    rnd_digits_c = '0;
    for (int i = 0; i < 5; i++) begin
      nib_c = acc[4 + 4*i +: 4];
      if (carry_c) begin
        if (nib_c == 4'd9) begin
          nib_c = 4'd0;
        end else begin
          nib_c   = nib_c + 4'd1;
          carry_c = 1'b0;
        end
      end
      rnd_digits_c[4*i +: 4] = nib_c;
    end
    rnd_hi_c  = (acc[27:24] != 4'd0);
    rnd_ovf_c = 1'b0;
    if (carry_c) begin
      if (acc[27:24] == 4'd0) begin
        rnd_hi_c = 1'b1;
      end else begin
        rnd_hi_c     = 1'b1;
        rnd_digits_c = 20'h99999;
        rnd_ovf_c    = 1'b1;
      end
    end
    if (ovf_q) begin
      rnd_hi_c     = 1'b1;
      rnd_digits_c = 20'h99999;
      rnd_ovf_c    = 1'b1;
    end
  end

`ifndef BCD_SIGNED_EN
  assign out_neg = 1'b0;
`else
  logic neg_q;
`endif

  // Control FSM with conversion datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_hi     <= 1'b0;
      out_digits <= '0;
      out_ovf    <= 1'b0;
      acc        <= '0;
      shreg      <= '0;
      cnt        <= '0;
      ovf_q      <= 1'b0;
`ifdef BCD_SIGNED_EN
      neg_q      <= 1'b0;
      out_neg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= mag_c;
            acc      <= '0;
            cnt      <= CNT_W'(BIN_W);
            ovf_q    <= (CMP_W'(mag_c) > MAX_VAL);
`ifdef BCD_SIGNED_EN
            neg_q    <= in_bin[BIN_W-1];
`endif
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          acc   <= {acc_adj_c, shreg[BIN_W-1]};
          shreg <= {shreg[BIN_W-2:0], 1'b0};
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          out_hi     <= rnd_hi_c;
          out_digits <= rnd_digits_c;
          out_ovf    <= rnd_ovf_c;
`ifdef BCD_SIGNED_EN
          out_neg    <= neg_q & (rnd_hi_c | (|rnd_digits_c));
`endif
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
